frame_ctrl: RTL
===============

# frame_ctrl

Sequencing controller for the 70-bit serial-in/parallel-out row loader feeding the FMA datapath. On `start` it gates the loader's shift enable and captures one frame of 12 parallel rows into a local row buffer, checking the loader's row index. It then hands the rows, in order, to the FMA operand stage over a valid/ready handshake and signals completion or a sequencing error.

## Interface
- `WIDTH`, 70: row word width, equal to the loader's `dout` width
- `ROWS`, 12: rows per frame, equal to the loader's row wrap value
- `RW`, 4: row index width

Ports:
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: begin a frame; sampled in IDLE or ERR only
- `abort` in 1: synchronous abort to IDLE; priority over `start`
- `src_valid` in 1: serial source has a valid bit this cycle
- `sipo_en` out 1: loader shift enable, combinational: `src_valid` AND state==COLLECT
- `sipo_load` in 1: loader word-ready flag
- `sipo_dout` in WIDTH: loader parallel word
- `sipo_row` in RW: loader row index, 1..ROWS
- `op_valid` out 1: dispatched row valid
- `op_ready` in 1: FMA operand stage accepts
- `op_data` out WIDTH: dispatched row word
- `op_row` out RW: dispatched row index, 1..ROWS
- `busy` out 1: high in COLLECT or DISPATCH
- `done` out 1: one-cycle pulse after the last row is accepted
- `err` out 1: sticky row-sequence error

## Operation
- States: IDLE, COLLECT, DISPATCH, ERR.
- IDLE: `start` -> COLLECT, with `exp_row` set to 1 and `err` cleared.
- COLLECT capture event: `sipo_load & ~load_q`, where `load_q` is `sipo_load` registered. Edge detection is required because the loader holds `load` high while disabled.
  - Capture with `sipo_row == exp_row`: write `sipo_dout` into buffer entry `exp_row-1`, then `exp_row++`.
  - Capture with `sipo_row != exp_row`: no write; go to ERR and set `err`.
  - Capture of row ROWS: go to DISPATCH, with `disp_row` set to 1.
- DISPATCH:
  - `op_valid` stays high with `op_data`=buf[`disp_row`-1] and `op_row`=`disp_row`.
  - On `op_valid & op_ready`, `disp_row++`.
  - Handshake on row ROWS: go to IDLE, `done` pulses, `op_valid` drops.
- ERR: `sipo_en`=0 and `op_valid`=0. `start` restarts as from IDLE and clears `err`.
- `abort` in any state: go to IDLE, clear `err`, no `done`, drop `op_valid` next cycle. This is the only permitted withdrawal of a pending `op_valid`.
- `start` in COLLECT or DISPATCH is ignored.
- `err` stays sticky until `start` from ERR, `abort`, or reset.
- The loader is not reset by this block. After an abort mid-frame, its row counter is out of phase, and the next frame flags `err` on the first capture. System software resets the loader in that case.

## Timing
- Reset values:
  - state IDLE
  - `sipo_en`, `op_valid`, `busy`, `done`, `err` all 0
  - `op_data` 0, `op_row` 0
  - `exp_row` 1, `load_q` 0
  - Buffer is not reset; it is never read before being written.
- `start` seen at edge N: `busy` and `sipo_en` (given `src_valid`) are high from cycle N+1.
- Capture at edge N: the buffer entry is valid from N+1. The ROWS-th capture makes `sipo_en` 0 and `op_valid` 1 in cycle N+1 (zero-bubble turnaround).
- While `op_valid & ~op_ready`, `op_data` and `op_row` hold stable.
- Back-to-back `op_ready` gives one row per cycle: 12 cycles for a frame.
- `done` is high in the single cycle after the final handshake, concurrent with IDLE. A `start` in that cycle is accepted.
- All outputs are registered except `sipo_en`.

## Structure
- Shared package `fma_ctrl_pkg`: state enum `frame_state_t` (IDLE, COLLECT, DISPATCH, ERR) and constants `ROW_WIDTH`=70, `FRAME_ROWS`=12, `ROW_IDX_W`=4, which the loader also uses.
- Sub-module `row_buf`: ROWS x WIDTH register file, one synchronous write port, one combinational read port, no reset.
- The FSM, row counters and handshake logic live in `frame_ctrl`.

## Test plan
- Nominal frame: `start`, continuous `src_valid`, loader model emits rows 1..12 with words 0x1..0xC, `op_ready`=1 -> `op_row` 1..12 on consecutive cycles carrying 0x1..0xC; `done` pulses once; `err`=0.
- Backpressure: `op_ready` low for 3 cycles on row 5 -> `op_data`/`op_row` hold 0x5/5 stable; no skipped or duplicated rows.
- Held load: loader leaves `load`=1 for 10 cycles after row 12 -> exactly one capture; no ERR.
- Sequence error: loader emits row 3 where row 2 is expected -> ERR next cycle, `err`=1, `sipo_en`=0, no `op_valid`; `start` clears `err` and re-enters COLLECT.
- Abort: `abort` during DISPATCH at row 7 -> IDLE; `op_valid` drops next cycle; no `done`. `abort`+`start` in the same cycle -> stays IDLE.
- Async reset: drop `rst_n` mid-COLLECT -> all outputs at their reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/fma_ctrl_pkg.sv
// Shared definitions for the FMA row-loader sequencing logic.
// The loader and frame_ctrl both size themselves from these constants.
package fma_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPATCH = 2'd2,
    ERR      = 2'd3
  } frame_state_t;

  localparam int ROW_WIDTH  = 70;
  localparam int FRAME_ROWS = 12;
  localparam int ROW_IDX_W  = 4;

endpackage

// File: rtl/row_buf.sv
// Frame row buffer: one synchronous write port, one combinational read port.
// Entries are not reset; every entry is written before it is read.
module row_buf #(
  parameter int WIDTH = 70,
  parameter int ROWS  = 12,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/frame_ctrl.sv
// Frame sequencer: captures ROWS loader words into row_buf, then dispatches
// them in order over a valid/ready handshake to the FMA operand stage.
module frame_ctrl
  import fma_ctrl_pkg::*;
#(
  parameter int WIDTH = ROW_WIDTH,
  parameter int ROWS  = FRAME_ROWS,
  parameter int RW    = ROW_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             src_valid,
  output logic             sipo_en,
  input  logic             sipo_load,
  input  logic [WIDTH-1:0] sipo_dout,
  input  logic [RW-1:0]    sipo_row,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [WIDTH-1:0] op_data,
  output logic [RW-1:0]    op_row,
  output logic             busy,
  output logic             done,
  output logic             err
);

  frame_state_t     state, state_nxt;
  logic [RW-1:0]    exp_row, exp_row_nxt;
  logic [RW-1:0]    disp_row, disp_row_nxt;
  logic             load_q;
  logic             capture, row_ok, hs, we;
  logic [RW-1:0]    waddr, raddr;
  logic [WIDTH-1:0] rdata;
  logic             op_valid_nxt, busy_nxt, done_nxt, err_nxt;
  logic [WIDTH-1:0] op_data_nxt;
  logic [RW-1:0]    op_row_nxt;

  // The loader keeps load high while its shift is gated, so only the rising
  // edge marks a fresh word.
  assign capture = (state == COLLECT) & sipo_load & ~load_q;
  assign row_ok  = (sipo_row == exp_row);
  assign hs      = (state == DISPATCH) & op_valid & op_ready;
  assign we      = capture & row_ok & ~abort;
  assign waddr   = exp_row - RW'(1);
  assign raddr   = disp_row_nxt - RW'(1);
  assign sipo_en = src_valid & (state == COLLECT);

  row_buf #(.WIDTH(WIDTH), .ROWS(ROWS), .AW(RW)) u_row_buf (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (sipo_dout),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      exp_row  <= RW'(1);
      disp_row <= RW'(1);
      load_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      exp_row  <= exp_row_nxt;
      disp_row <= disp_row_nxt;
      load_q   <= sipo_load;
    end
  end

  always_comb begin
    state_nxt    = state;
    exp_row_nxt  = exp_row;
    disp_row_nxt = disp_row;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, ERR: begin
          if (start) begin
            state_nxt   = COLLECT;
            exp_row_nxt = RW'(1);
          end
        end
        COLLECT: begin
          if (capture) begin
            if (!row_ok) begin
              state_nxt = ERR;
            end else begin
              exp_row_nxt = exp_row + RW'(1);
              if (exp_row == RW'(ROWS)) begin
                state_nxt    = DISPATCH;
                disp_row_nxt = RW'(1);
              end
            end
          end
        end
        DISPATCH: begin
          if (hs) begin
            if (disp_row == RW'(ROWS)) state_nxt = IDLE;
            else disp_row_nxt = disp_row + RW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // err tracks the ERR state exactly: only start or abort leave ERR.
  always_comb begin
    op_valid_nxt = (state_nxt == DISPATCH);
    busy_nxt     = (state_nxt == COLLECT) | (state_nxt == DISPATCH);
    err_nxt      = (state_nxt == ERR);
    done_nxt     = hs & (disp_row == RW'(ROWS)) & ~abort;
    op_row_nxt   = op_valid_nxt ? disp_row_nxt : '0;
    op_data_nxt  = '0;
    if (op_valid_nxt) op_data_nxt = (we && waddr == raddr) ? sipo_dout : rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid <= 1'b0;
      op_data  <= '0;
      op_row   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      op_valid <= op_valid_nxt;
      op_data  <= op_data_nxt;
      op_row   <= op_row_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

endmodule
